// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's load/store path and dmem_responder.
// The core drives the master modport; the responder uses the slave modport.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_wen;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT wait states, word RAM in byte lanes.
// Define DMEM_MISALIGN_TRAP_EN to fault on req_addr[1:0] != 0 instead of word-aligning.
module dmem_responder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int NLANE = XLEN / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [AW-1:0]    idx_reg;
  logic             wen_reg;
  logic             err_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic             rdata_vld_reg;
  logic [XLEN-1:0]  ram_q;

  logic [AW-1:0]    req_idx;
  logic [AW-1:0]    rd_idx;
  logic             req_oor;
  logic             req_err;
  logic             accept;
  logic             wait_done;
  logic             enter_resp;
  logic             rd_load;
  logic             rd_en;
  logic             wr_en;

  assign req_idx = bus.req_addr[AW+1:2];
  assign req_oor = |bus.req_addr[XLEN-1:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_err = req_oor || (bus.req_addr[1:0] != 2'b00);
`else
  // Byte offset is dropped: the access is treated as word-aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.req_addr[1:0]};
  assign req_err = req_oor;
`endif

  assign bus.req_ready = (state_reg == ST_IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign wait_done     = (state_reg == ST_WAIT) && (wait_cnt_reg == CNT_W'(WAIT - 1));
  assign enter_resp    = (WAIT == 0) ? accept : wait_done;

  // With WAIT=0 the RAM read happens on the accept edge, before the latches are valid.
  assign rd_idx  = (state_reg == ST_IDLE) ? req_idx : idx_reg;
  assign rd_load = (state_reg == ST_IDLE) ? (!bus.req_wen && !req_err) : (!wen_reg && !err_reg);
  assign rd_en   = enter_resp && rd_load;
  assign wr_en   = accept && bus.req_wen && !req_err;

  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && bus.req_wstrb[gi]) begin
          mem[req_idx] <= bus.req_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          q_reg <= mem[rd_idx];
        end
      end

      assign ram_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      idx_reg       <= '0;
      wen_reg       <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rdata_vld_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            idx_reg      <= req_idx;
            wen_reg      <= bus.req_wen;
            err_reg      <= req_err;
            wait_cnt_reg <= '0;
            if (WAIT == 0) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= req_err;
              rdata_vld_reg <= !bus.req_wen && !req_err;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= err_reg;
            rdata_vld_reg <= !wen_reg && !err_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rdata_vld_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM output register stays reset-free; the qualifier forces 0 for stores, errors and idle.
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rdata_vld_reg ? ram_q : '0;

endmodule
